jtpang_objdma: RTL and testbench



---
 rtl/jtpang_pkg.sv | 16 +
 rtl/jtpang_objdma.sv | 104 ++++++++++
 tb/tb_jtpang_objdma.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/jtpang_pkg.sv
// Shared types and default geometry for the Pang object DMA engine.
package jtpang_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        COPY,
        REL
    } dma_state_t;

    localparam int unsigned DEF_SRC_AW   = 12;
    localparam int unsigned DEF_DST_AW   = 9;
    localparam int unsigned DEF_SRC_BASE = 32'h000;
    localparam int unsigned OBJ_BYTES    = 1 << DEF_DST_AW;

endpackage

// File: rtl/jtpang_objdma.sv
// Object-attribute DMA: grabs the Z80 bus and copies a video-RAM block
// into the double-buffered object line RAM.
module jtpang_objdma
    import jtpang_pkg::*;
#(
    parameter int unsigned SRC_AW   = DEF_SRC_AW,
    parameter int unsigned DST_AW   = DEF_DST_AW,
    parameter int unsigned SRC_BASE = DEF_SRC_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              dma_go,
    output logic              busrq_n,
    input  logic              busak_n,
    output logic              dma_busy,
    output logic [SRC_AW-1:0] src_addr,
    output logic              src_cs,
    input  logic [7:0]        src_dout,
    output logic [DST_AW-1:0] obj_addr,
    output logic [7:0]        obj_din,
    output logic              obj_we,
    output logic              obj_page
);

    localparam int unsigned       NBYTES = 1 << DST_AW;
    localparam logic [SRC_AW-1:0] BASE   = SRC_AW'(SRC_BASE);
    localparam logic [SRC_AW-1:0] LAST   = SRC_AW'(SRC_BASE + NBYTES - 1);
    localparam logic [DST_AW:0]   TERM   = (DST_AW+1)'(NBYTES - 1);

    dma_state_t      state;
    logic [DST_AW:0] cnt;
    logic            last_go;
    logic            rd_pend;   // read issued on the previous cen, data on src_dout now
    logic            we_r;

    assign obj_we = we_r & cen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busrq_n  <= 1'b1;
            dma_busy <= 1'b0;
            src_cs   <= 1'b0;
            src_addr <= BASE;
            obj_addr <= '0;
            obj_din  <= '0;
            obj_page <= 1'b0;
            cnt      <= '0;
            last_go  <= 1'b0;
            rd_pend  <= 1'b0;
            we_r     <= 1'b0;
        end else if (cen) begin
            last_go <= dma_go;
            we_r    <= 1'b0;
            case (state)
                IDLE: if (dma_go && !last_go) begin
                    state    <= REQ;
                    busrq_n  <= 1'b0;
                    dma_busy <= 1'b1;
                    cnt      <= '0;
                end
                REQ: if (!busak_n) begin
                    state    <= COPY;
                    src_cs   <= 1'b1;
                    src_addr <= BASE;
                    rd_pend  <= 1'b0;
                end
                COPY: begin
                    if (busak_n) begin
                        // Data in flight is lost with the bus: rewind to the first
                        // unwritten byte so re-ack re-issues it before writing.
                        rd_pend  <= 1'b0;
                        src_cs   <= 1'b1;
                        src_addr <= BASE + SRC_AW'(cnt);
                    end else begin
                        rd_pend <= src_cs;
                        if (src_cs) begin
                            src_addr <= src_addr + SRC_AW'(1);
                            if (src_addr == LAST) src_cs <= 1'b0;
                        end
                        if (rd_pend) begin
                            we_r     <= 1'b1;
                            obj_addr <= cnt[DST_AW-1:0];
                            obj_din  <= src_dout;
                            cnt      <= cnt + (DST_AW+1)'(1);
                            if (cnt == TERM) begin
                                state    <= REL;
                                busrq_n  <= 1'b1;
                                obj_page <= ~obj_page;
                            end
                        end
                    end
                end
                REL: if (busak_n) begin
                    state    <= IDLE;
                    dma_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma: default base plus a wrapped-base copy
// driven by the same bus handshake.
module tb_jtpang_objdma;
    import jtpang_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        dma_go = 1'b0;
    logic        busak_n = 1'b1;
    int unsigned cen_div = 2;
    int unsigned phase = 0;

    logic        busrq_n0, dma_busy0, src_cs0, obj_we0, obj_page0;
    logic [11:0] src_addr0;
    logic [7:0]  src_dout0, obj_din0;
    logic [8:0]  obj_addr0;
    logic        busrq_n1, dma_busy1, src_cs1, obj_we1, obj_page1;
    logic [11:0] src_addr1;
    logic [7:0]  src_dout1, obj_din1;
    logic [8:0]  obj_addr1;

    int n_chk = 0;
    int n_err = 0;
    int wr0 = 0, wr1 = 0, rq_falls = 0;
    logic [7:0] cap0_200, cap1_0, cap1_255, cap1_256;

    jtpang_objdma u0 (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go),
        .busrq_n(busrq_n0), .busak_n(busak_n), .dma_busy(dma_busy0),
        .src_addr(src_addr0), .src_cs(src_cs0), .src_dout(src_dout0),
        .obj_addr(obj_addr0), .obj_din(obj_din0), .obj_we(obj_we0), .obj_page(obj_page0)
    );

    jtpang_objdma #(.SRC_AW(12), .DST_AW(9), .SRC_BASE(32'hF00)) u1 (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go),
        .busrq_n(busrq_n1), .busak_n(busak_n), .dma_busy(dma_busy1),
        .src_addr(src_addr1), .src_cs(src_cs1), .src_dout(src_dout1),
        .obj_addr(obj_addr1), .obj_din(obj_din1), .obj_we(obj_we1), .obj_page(obj_page1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        phase = phase + 1;
        cen = (phase % cen_div) == 0;
    end

    function automatic logic [7:0] vmod(input logic [11:0] a);
        return (a[7:0] ^ 8'h5A) ^ {5'd0, a[11:9]};
    endfunction

    // Video RAM: one-cen read latency
    always @(posedge clk) if (cen) begin
        src_dout0 <= vmod(src_addr0);
        src_dout1 <= vmod(src_addr1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitors
    logic        mon_en = 1'b0;
    logic        ecen_q = 1'b0, erst_q = 1'b1, ak_q = 1'b1, rq_prev = 1'b1, have_snap = 1'b0;
    logic [63:0] snap;

    always @(posedge clk) begin
        ecen_q <= cen;
        erst_q <= rst;
        if (cen) ak_q <= busak_n;
    end

    always @(negedge clk) if (mon_en) begin
        if (have_snap && !ecen_q && !erst_q)
            check("cen_gate", {busrq_n0, dma_busy0, src_cs0, src_addr0, obj_addr0, obj_din0, obj_page0}, snap);
        snap = {31'd0, busrq_n0, dma_busy0, src_cs0, src_addr0, obj_addr0, obj_din0, obj_page0};
        have_snap = 1'b1;
        if (!cen) check("we_gated", obj_we0, 1'b0);
        if (cen && ak_q) check("gap_we", {obj_we0, obj_we1}, 2'b00);
        if (rq_prev && !busrq_n0) rq_falls = rq_falls + 1;
        rq_prev = busrq_n0;
        if (obj_we0) begin
            check("wr0", {obj_addr0, obj_din0}, {wr0[8:0], vmod(12'(wr0))});
            if (wr0 == 200) cap0_200 = obj_din0;
            wr0 = wr0 + 1;
        end
        if (obj_we1) begin
            check("wr1", {obj_addr1, obj_din1}, {wr1[8:0], vmod(12'hF00 + 12'(wr1))});
            if (wr1 == 0)   cap1_0   = obj_din1;
            if (wr1 == 255) cap1_255 = obj_din1;
            if (wr1 == 256) cap1_256 = obj_din1;
            wr1 = wr1 + 1;
        end
    end

    task automatic step_cen();
        do @(posedge clk); while (!cen);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step_cen();
    endtask

    task automatic wait_wr(input int n);
        for (int k = 0; k < 3000 && wr0 < n; k++) step_cen();
        check("wr_reach", (wr0 >= n), 1'b1);
    endtask

    task automatic start_xfer();
        wr0 = 0; wr1 = 0; rq_falls = 0;
        dma_go = 1'b1;
        step_cen();
        check("rq_low", {busrq_n0, busrq_n1}, 2'b00);
        check("busy_on", {dma_busy0, dma_busy1}, 2'b11);
        steps(2);
        busak_n = 1'b0;
        step_cen();
        dma_go = 1'b0;
    endtask

    task automatic finish_xfer(input logic page);
        wait_wr(512);
        for (int k = 0; k < 50 && !busrq_n0; k++) step_cen();
        check("rq_release", {busrq_n0, busrq_n1}, 2'b11);
        check("page", {obj_page0, obj_page1}, {page, page});
        check("busy_hold", dma_busy0, 1'b1);
        busak_n = 1'b1;
        steps(2);
        check("busy_off", {dma_busy0, dma_busy1}, 2'b00);
        steps(3);
        check("wr_total", {wr0[15:0], wr1[15:0]}, {16'd512, 16'd512});
        check("rq_count", rq_falls, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        check("rst_state0", {busrq_n0, dma_busy0, src_cs0, obj_we0, src_addr0, obj_addr0, obj_din0, obj_page0},
              {1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 9'd0, 8'h00, 1'b0});
        check("rst_state1", {busrq_n1, dma_busy1, src_cs1, src_addr1, obj_page1},
              {1'b1, 1'b0, 1'b0, 12'hF00, 1'b0});
        steps(3);

        // Basic copy and wrapped-base copy
        start_xfer();
        finish_xfer(1'b1);
        check("wrap_first", cap1_0, 8'h5D);
        check("wrap_fff", cap1_255, 8'hA2);
        check("wrap_000", cap1_256, 8'h5A);

        // Retrigger during COPY is ignored
        steps(3);
        start_xfer();
        wait_wr(100);
        dma_go = 1'b1;
        steps(3);
        dma_go = 1'b0;
        finish_xfer(1'b0);
        steps(10);
        check("no_requeue", {busrq_n0, dma_busy0}, 2'b10);

        // Bus stolen mid-copy
        start_xfer();
        wait_wr(200);
        busak_n = 1'b1;
        steps(10);
        check("rq_held", busrq_n0, 1'b0);
        busak_n = 1'b0;
        finish_xfer(1'b1);
        check("stolen_200", cap0_200, 8'h92);

        // Reset mid-copy
        steps(3);
        start_xfer();
        wait_wr(300);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid", {busrq_n0, dma_busy0, obj_page0, src_cs0, obj_we0}, 5'b10000);
        rst = 1'b0;
        busak_n = 1'b1;
        steps(4);
        start_xfer();
        finish_xfer(1'b1);

        // Sparse clock enable
        cen_div = 8;
        steps(3);
        start_xfer();
        finish_xfer(1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
